// File: rtl/arcade_video_timing.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : arcade_video_timing
//  Description : Raster timing generator with a pixel-alignment pipeline.
//                Produces hcnt/vcnt for the pixel generator, captures RGB_in
//                after LAT ce_pix ticks, and emits RGB, blanks and syncs
//                mutually aligned on clk_video / ce_pix.
//  Revision    : 1.0  initial release
// ============================================================================
module arcade_video_timing #(
    parameter int DW       = 8,
    parameter int H_TOTAL  = 320,
    parameter int H_ACTIVE = 256,
    parameter int HS_START = 272,
    parameter int HS_LEN   = 32,
    parameter int V_TOTAL  = 262,
    parameter int V_ACTIVE = 224,
    parameter int VS_START = 236,
    parameter int VS_LEN   = 4,
    parameter int LAT      = 2
) (
    input  logic          clk_video,
    input  logic          reset_n,
    input  logic          ce_pix,
    output logic [9:0]    hcnt,
    output logic [8:0]    vcnt,
    input  logic [DW-1:0] RGB_in,
    output logic [DW-1:0] RGB_out,
    output logic          HBlank,
    output logic          VBlank,
    output logic          HSync,
    output logic          VSync,
    output logic          line_start,
    output logic          frame_start
);

    // Reject geometries the counters or the downstream rotator cannot handle.
    if (H_TOTAL > 1024 || V_TOTAL > 512 ||
        !(H_ACTIVE < H_TOTAL) || !(V_ACTIVE < V_TOTAL) ||
        (HS_START + HS_LEN > H_TOTAL) || (VS_START + VS_LEN > V_TOTAL) ||
        LAT > 7 || LAT < 0) begin : g_param_check
        $error("arcade_video_timing: illegal timing parameters");
    end

    // Comparison constants; sync ends are one bit wider so a window that
    // ends exactly at a 1024/512 total still compares correctly.
    localparam logic [9:0]  C_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [8:0]  C_V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [9:0]  C_H_ACTIVE = 10'(H_ACTIVE);
    localparam logic [8:0]  C_V_ACTIVE = 9'(V_ACTIVE);
    localparam logic [10:0] C_HS_START = 11'(HS_START);
    localparam logic [10:0] C_HS_END   = 11'(HS_START + HS_LEN);
    localparam logic [9:0]  C_VS_START = 10'(VS_START);
    localparam logic [9:0]  C_VS_END   = 10'(VS_START + VS_LEN);
    // Flag order everywhere: {hb, vb, hs, vs}; reset is "blank, no sync".
    localparam logic [3:0]  C_FLAGS_RESET = 4'b1100;

    logic       w_hb;
    logic       w_vb;
    logic       w_hs;
    logic       w_vs;
    logic [3:0] w_flags;
    logic [3:0] w_sel;

    // Raster counters plus the one-clk line/frame pulses tied to the wrap.
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            hcnt        <= '0;
            vcnt        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (ce_pix) begin
                if (hcnt == C_H_LAST) begin
                    hcnt       <= '0;
                    line_start <= 1'b1;
                    if (vcnt == C_V_LAST) begin
                        vcnt        <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        vcnt <= vcnt + 9'd1;
                    end
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
            end
        end
    end

    // Raw timing flags for the coordinate currently presented.
    assign w_hb    = (hcnt >= C_H_ACTIVE);
    assign w_vb    = (vcnt >= C_V_ACTIVE);
    assign w_hs    = ({1'b0, hcnt} >= C_HS_START) && ({1'b0, hcnt} < C_HS_END);
    assign w_vs    = ({1'b0, vcnt} >= C_VS_START) && ({1'b0, vcnt} < C_VS_END);
    assign w_flags = {w_hb, w_vb, w_hs, w_vs};

    if (LAT == 0) begin : g_no_delay
        assign w_sel = w_flags;
    end else begin : g_delay
        logic [3:0] r_stage [LAT];

        // Delay the flags by LAT ticks so they line up with the fetched pixel.
        always_ff @(posedge clk_video or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < LAT; i++) begin
                    r_stage[i] <= C_FLAGS_RESET;
                end
            end else if (ce_pix) begin
                r_stage[0] <= w_flags;
                for (int i = 1; i < LAT; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign w_sel = r_stage[LAT-1];
    end

    // Aligned output register; pixels are forced to zero during blanking.
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            HBlank  <= 1'b1;
            VBlank  <= 1'b1;
            HSync   <= 1'b0;
            VSync   <= 1'b0;
            RGB_out <= '0;
        end else if (ce_pix) begin
            HBlank  <= w_sel[3];
            VBlank  <= w_sel[2];
            HSync   <= w_sel[1];
            VSync   <= w_sel[0];
            RGB_out <= (w_sel[3] | w_sel[2]) ? '0 : RGB_in;
        end
    end

endmodule
`default_nettype wire
